std_div_issue: RTL and testbench



---
 rtl/std_div_issue.sv | 189 ++++++++++++++++++
 tb/tb_std_div_issue.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/std_div_issue.sv
// Operand FIFO and go/done issue controller in front of an iterative divider.
// Optional STD_DIV_ZERO_BYPASS_EN answers zero divisors locally instead of issuing them.
module std_div_issue #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_left,
    input  logic [WIDTH-1:0] in_right,
    output logic             unit_go,
    output logic [WIDTH-1:0] unit_left,
    output logic [WIDTH-1:0] unit_right,
    input  logic             unit_done,
    input  logic [WIDTH-1:0] unit_quotient,
    input  logic [WIDTH-1:0] unit_remainder,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             err_timeout
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t state;
    state_t state_d;

    logic [WIDTH-1:0] mem_left  [DEPTH];
    logic [WIDTH-1:0] mem_right [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;
    logic             empty;
    logic             full;
    logic             slot_free;

    logic [TW-1:0]    wd_cnt;
    logic [TW-1:0]    wd_cnt_d;
    logic             go_d;
    logic             load_op;
    logic             load_res;
    logic             set_err;
    logic             out_valid_d;
    logic [WIDTH-1:0] res_q_d;
    logic [WIDTH-1:0] res_r_d;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign in_ready  = !full;
    assign push      = in_valid && !full;
    assign slot_free = !out_valid || out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state, pop decision and next values of the registered outputs.
    always_comb begin
        state_d  = state;
        pop      = 1'b0;
        go_d     = unit_go;
        load_op  = 1'b0;
        load_res = 1'b0;
        set_err  = 1'b0;
        wd_cnt_d = wd_cnt;
        res_q_d  = unit_quotient;
        res_r_d  = unit_remainder;
        unique case (state)
            IDLE: begin
                if (!empty && slot_free) begin
                    pop = 1'b1;
`ifdef STD_DIV_ZERO_BYPASS_EN
                    if (mem_right[rd_ptr] == '0) begin
                        load_res = 1'b1;
                        res_q_d  = '1;
                        res_r_d  = mem_left[rd_ptr];
                        state_d  = GAP;
                    end else begin
                        load_op  = 1'b1;
                        go_d     = 1'b1;
                        wd_cnt_d = '0;
                        state_d  = BUSY;
                    end
`else
                    load_op  = 1'b1;
                    go_d     = 1'b1;
                    wd_cnt_d = '0;
                    state_d  = BUSY;
`endif
                end
            end
            BUSY: begin
                if (unit_done) begin
                    load_res = 1'b1;
                    go_d     = 1'b0;
                    state_d  = GAP;
                end else if (wd_cnt == TW'(TIMEOUT - 1)) begin
                    set_err = 1'b1;
                    go_d    = 1'b0;
                    state_d = GAP;
                end else begin
                    wd_cnt_d = wd_cnt + TW'(1);
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        out_valid_d = load_res ? 1'b1 : (out_valid && !out_ready);
    end

    // FIFO storage; contents need no reset since count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_left[wr_ptr]  <= in_left;
            mem_right[wr_ptr] <= in_right;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            unit_go       <= 1'b0;
            unit_left     <= '0;
            unit_right    <= '0;
            wd_cnt        <= '0;
            out_valid     <= 1'b0;
            out_quotient  <= '0;
            out_remainder <= '0;
            err_timeout   <= 1'b0;
        end else begin
            unit_go   <= go_d;
            wd_cnt    <= wd_cnt_d;
            out_valid <= out_valid_d;
            if (load_op) begin
                unit_left  <= mem_left[rd_ptr];
                unit_right <= mem_right[rd_ptr];
            end
            if (load_res) begin
                out_quotient  <= res_q_d;
                out_remainder <= res_r_d;
            end
            if (set_err) begin
                err_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_std_div_issue.sv
// Directed bench for std_div_issue with a behavioural go/done divider responder.
module tb_std_div_issue;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 64;
    localparam int          LAT     = 33;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_left;
    logic [WIDTH-1:0] in_right;
    logic             unit_go;
    logic [WIDTH-1:0] unit_left;
    logic [WIDTH-1:0] unit_right;
    logic             unit_done;
    logic [WIDTH-1:0] unit_quotient;
    logic [WIDTH-1:0] unit_remainder;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_quotient;
    logic [WIDTH-1:0] out_remainder;
    logic             err_timeout;

    std_div_issue #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_left        (in_left),
        .in_right       (in_right),
        .unit_go        (unit_go),
        .unit_left      (unit_left),
        .unit_right     (unit_right),
        .unit_done      (unit_done),
        .unit_quotient  (unit_quotient),
        .unit_remainder (unit_remainder),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_quotient   (out_quotient),
        .out_remainder  (out_remainder),
        .err_timeout    (err_timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Divider stand-in: done pulses LAT cycles after go rises, unless disabled.
    logic model_en;
    int   mcnt;
    logic mseen;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            unit_done      <= 1'b0;
            unit_quotient  <= '0;
            unit_remainder <= '0;
            mcnt           <= 0;
            mseen          <= 1'b0;
        end else begin
            unit_done <= 1'b0;
            if (!unit_go) begin
                mcnt  <= 0;
                mseen <= 1'b0;
            end else if (!mseen) begin
                if (mcnt == LAT - 1) begin
                    mseen <= 1'b1;
                    if (model_en) begin
                        unit_done <= 1'b1;
                        if (unit_right == '0) begin
                            unit_quotient  <= '1;
                            unit_remainder <= unit_left;
                        end else begin
                            unit_quotient  <= unit_left / unit_right;
                            unit_remainder <= unit_left % unit_right;
                        end
                    end
                end else begin
                    mcnt <= mcnt + 1;
                end
            end
        end
    end

    // Result collector and go-edge monitor, sampled mid-cycle.
    logic [63:0] rx_q[$];
    int   go_rises     = 0;
    int   low_run      = 0;
    int   last_low_run = 0;
    logic prev_go      = 1'b0;
    always @(negedge clk) begin
        if (reset_n) begin
            if (out_valid && out_ready) rx_q.push_back({out_quotient, out_remainder});
            if (unit_go && !prev_go) begin
                go_rises     = go_rises + 1;
                last_low_run = low_run;
            end
            if (unit_go) low_run = 0;
            else         low_run = low_run + 1;
        end
        prev_go = unit_go;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int k;
        k        = 0;
        in_valid = 1'b1;
        in_left  = a;
        in_right = b;
        while (!in_ready && k < 500) begin
            step();
            k++;
        end
        chk("push_accept", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k;
        k = 0;
        while (rx_q.size() < n && k < budget) begin
            step();
            k++;
        end
        chk("rx_count", 64'(rx_q.size()), 64'(n));
    endtask

    logic [WIDTH-1:0] bp_a [6] = '{32'd1000, 32'd77, 32'd64, 32'd99, 32'd12345, 32'd7};
    logic [WIDTH-1:0] bp_b [6] = '{32'd3,    32'd10, 32'd8,  32'd4,  32'd100,   32'd9};
    logic [63:0]      bp_e [6] = '{{32'd333, 32'd1}, {32'd7, 32'd7}, {32'd8, 32'd0},
                                   {32'd24, 32'd3}, {32'd123, 32'd45}, {32'd0, 32'd7}};

    initial begin
        int          k;
        int          t0;
        int          g0;
        logic [63:0] exp_q[$];

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_left   = '0;
        in_right  = '0;
        out_ready = 1'b0;
        model_en  = 1'b1;
        repeat (3) step();
        chk("rst_go",   64'(unit_go),       64'd0);
        chk("rst_left", 64'(unit_left),     64'd0);
        chk("rst_right",64'(unit_right),    64'd0);
        chk("rst_oval", 64'(out_valid),     64'd0);
        chk("rst_q",    64'(out_quotient),  64'd0);
        chk("rst_r",    64'(out_remainder), 64'd0);
        chk("rst_err",  64'(err_timeout),   64'd0);
        reset_n = 1'b1;
        step();
        chk("rst_inrdy", 64'(in_ready), 64'd1);

        // Single operation and issue latency.
        out_ready = 1'b1;
        rx_q.delete();
        push(32'd100, 32'd7);
        chk("lat_go_low", 64'(unit_go), 64'd0);
        step();
        chk("lat_go_high", 64'(unit_go),    64'd1);
        chk("lat_left",    64'(unit_left),  64'd100);
        chk("lat_right",   64'(unit_right), 64'd7);
        k = 0;
        while (!out_valid && k < 200) begin
            step();
            k++;
        end
        chk("single_valid", 64'(out_valid),     64'd1);
        chk("single_q",     64'(out_quotient),  64'd14);
        chk("single_r",     64'(out_remainder), 64'd2);
        step();
        chk("single_pulse", 64'(out_valid), 64'd0);
        wait_rx(1, 50);
        chk("single_rx", rx_q[0], {32'd14, 32'd2});

        // Two queued ops: go must stay low two cycles between them.
        rx_q.delete();
        push(32'd50, 32'd5);
        push(32'd81, 32'd9);
        wait_rx(2, 300);
        chk("b2b_rx0", rx_q[0], {32'd10, 32'd0});
        chk("b2b_rx1", rx_q[1], {32'd9, 32'd0});
        chk("b2b_gap", 64'(last_low_run), 64'd2);

        // Backpressure: fill FIFO behind a held result.
        rx_q.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(bp_a[i], bp_b[i]);
        chk("bp_full", 64'(in_ready), 64'd0);
        in_valid = 1'b1;
        in_left  = bp_a[5];
        in_right = bp_b[5];
        k = 0;
        while (!out_valid && k < 200) begin
            step();
            k++;
        end
        repeat (5) step();
        chk("bp_hold_v",  64'(out_valid),     64'd1);
        chk("bp_hold_q",  64'(out_quotient),  64'd333);
        chk("bp_hold_r",  64'(out_remainder), 64'd1);
        chk("bp_still_full", 64'(in_ready),   64'd0);
        out_ready = 1'b1;
        push(bp_a[5], bp_b[5]);
        wait_rx(6, 800);
        for (int i = 0; i < 6; i++) chk($sformatf("bp_rx%0d", i), rx_q[i], bp_e[i]);

        // Streaming run across several pointer wraps.
        rx_q.delete();
        exp_q.delete();
        for (int i = 0; i < 20; i++) begin
            push(32'(i * 1000 + 37), 32'(i + 2));
            exp_q.push_back({32'((i * 1000 + 37) / (i + 2)), 32'((i * 1000 + 37) % (i + 2))});
        end
        wait_rx(20, 2500);
        for (int i = 0; i < 20; i++) chk($sformatf("stream%0d", i), rx_q[i], exp_q[i]);

        // Watchdog: first op never completes, second one does.
        rx_q.delete();
        model_en = 1'b0;
        push(32'd9, 32'd3);
        push(32'd20, 32'd4);
        chk("wd_go", 64'(unit_go), 64'd1);
        t0 = cyc;
        k  = 0;
        while (!err_timeout && k < 300) begin
            step();
            k++;
        end
        chk("wd_err",    64'(err_timeout), 64'd1);
        chk("wd_cycles", 64'(cyc - t0),    64'(TIMEOUT));
        chk("wd_go_drop",64'(unit_go),     64'd0);
        model_en = 1'b1;
        wait_rx(1, 300);
        repeat (20) step();
        chk("wd_rx_n",  64'(rx_q.size()), 64'd1);
        chk("wd_rx0",   rx_q[0], {32'd5, 32'd0});
        chk("wd_sticky",64'(err_timeout), 64'd1);

        // Zero divisor.
        rx_q.delete();
        g0 = go_rises;
        push(32'd5, 32'd0);
        wait_rx(1, 300);
        chk("zero_rx", rx_q[0], {32'hFFFF_FFFF, 32'd5});
`ifdef STD_DIV_ZERO_BYPASS_EN
        chk("zero_go", 64'(go_rises - g0), 64'd0);
`else
        chk("zero_go", 64'(go_rises - g0), 64'd1);
`endif

        // Reset while busy with two operands queued.
        push(32'd40, 32'd3);
        push(32'd41, 32'd3);
        push(32'd42, 32'd3);
        repeat (4) step();
        chk("mr_busy", 64'(unit_go), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("mr_go",    64'(unit_go),     64'd0);
        chk("mr_inrdy", 64'(in_ready),    64'd1);
        chk("mr_oval",  64'(out_valid),   64'd0);
        chk("mr_err",   64'(err_timeout), 64'd0);
        step();
        step();
        reset_n = 1'b1;
        rx_q.delete();
        g0 = go_rises;
        repeat (100) step();
        chk("mr_no_rx", 64'(rx_q.size()),    64'd0);
        chk("mr_no_go", 64'(go_rises - g0),  64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
